// File: rtl/restoring_divider_if.sv
// restoring_divider_if
//   Start/done handshake and operand/result bundle for the restoring divider.
//   The same handshake is used by the shift-add multiplier, so the control
//   unit drives both blocks identically.
//   Ports (signals):
//     start      master -> slave   level request, sampled only while idle
//     dividend   master -> slave   numerator, latched at the accept edge
//     divisor    master -> slave   denominator, latched at the accept edge
//     busy       slave  -> master  high while an operation is running
//     done       slave  -> master  one-cycle pulse, results valid
//     quotient   slave  -> master  registered result, held until next done
//     remainder  slave  -> master  registered result, held until next done
//     divByZero  slave  -> master  latched divisor was zero, updated with done
interface restoring_divider_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             divByZero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, divByZero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, divByZero
    );
endinterface

// File: rtl/restoring_divider.sv
// restoring_divider
//   Sequential unsigned WIDTH/WIDTH divider using the restoring shift-subtract
//   algorithm, one quotient bit per clock. Fixed latency: done is high in the
//   cycle after the WIDTH-th edge following the accept edge.
//   Ports:
//     clockDiv  in   clock, all state changes on the rising edge
//     reset     in   synchronous, active-high; aborts any running operation
//     bus       slave modport of restoring_divider_if (handshake, operands,
//               results, divide-by-zero flag)
module restoring_divider #(
    parameter int WIDTH = 16
) (
    input  logic               clockDiv,
    input  logic               reset,
    restoring_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    count;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_by_zero_q;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // One restoring iteration: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The compare is one bit
    // wider than the operands so a full-scale remainder cannot overflow.
    // With a zero divisor the subtraction always "fits", which naturally
    // yields an all-ones quotient and a remainder equal to the dividend.
    always_comb begin
        trial = {rem, quo[WIDTH-1]};
        diff  = trial - {1'b0, dvs};
        if (trial >= {1'b0, dvs}) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM and datapath registers. Results are only written on the
    // final iteration so they stay stable between done pulses; a reset in
    // the middle of an operation discards it without a done pulse.
    always_ff @(posedge clockDiv) begin
        if (reset) begin
            state         <= IDLE;
            rem           <= '0;
            quo           <= '0;
            dvs           <= '0;
            count         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvs    <= bus.divisor;
                        quo    <= bus.dividend;
                        rem    <= '0;
                        count  <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        quotient_q    <= quo_next;
                        remainder_q   <= rem_next;
                        div_by_zero_q <= (dvs == '0);
                        done_q        <= 1'b1;
                        busy_q        <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.divByZero = div_by_zero_q;
endmodule
